// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep controller: steps a counter lo->hi->lo for n_cycles periods with start/done/abort/err.
// Define SWEEP_HOLD_EN to add a hold input that freezes an active sweep.
module updown_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
`ifdef SWEEP_HOLD_EN
  input  logic             hold,
`endif
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYC_W-1:0] n_cycles,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CYC_W-1:0] r_cycles_left;

  logic             w_hold;
  logic             w_active;
  logic             w_start_bad;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_cnt_dec;

`ifdef SWEEP_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_active    = (r_state == S_UP) || (r_state == S_DOWN);
  assign w_start_bad = (lo >= hi) || (n_cycles == {CYC_W{1'b0}});
  // count stays inside [r_lo, r_hi] while stepping, so these never wrap when used
  assign w_cnt_inc   = r_count + WIDTH'(1);
  assign w_cnt_dec   = r_count - WIDTH'(1);

  // Sweep state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_lo          <= {WIDTH{1'b0}};
      r_hi          <= {WIDTH{1'b0}};
      r_count       <= {WIDTH{1'b0}};
      r_dir         <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cycles_left <= {CYC_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_active && abort) begin
        r_state       <= S_IDLE;
        r_count       <= r_lo;
        r_dir         <= 1'b1;
        r_busy        <= 1'b0;
        r_cycles_left <= {CYC_W{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_start_bad) begin
                r_err <= 1'b1;
              end else begin
                r_lo          <= lo;
                r_hi          <= hi;
                r_count       <= lo;
                r_cycles_left <= n_cycles;
                r_dir         <= 1'b1;
                r_busy        <= 1'b1;
                r_state       <= S_UP;
              end
            end
          end
          S_UP: begin
            if (!w_hold) begin
              r_count <= w_cnt_inc;
              if (w_cnt_inc == r_hi) begin
                r_dir   <= 1'b0;
                r_state <= S_DOWN;
              end
            end
          end
          S_DOWN: begin
            if (!w_hold) begin
              r_count <= w_cnt_dec;
              if (w_cnt_dec == r_lo) begin
                if (r_cycles_left == CYC_W'(1)) begin
                  r_cycles_left <= {CYC_W{1'b0}};
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_state       <= S_DONE;
                end else begin
                  r_cycles_left <= r_cycles_left - CYC_W'(1);
                  r_dir         <= 1'b1;
                  r_state       <= S_UP;
                end
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign count       = r_count;
  assign dir         = r_dir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign cycles_left = r_cycles_left;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: stimulus queues expected outputs, a negedge monitor checks them.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       hold;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] n_cycles;
  logic [3:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cycles_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] c;
    logic       d;
    logic       b;
    logic       dn;
    logic       e;
    logic [3:0] cl;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  updown_sweep_ctrl #(.WIDTH(4), .CYC_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .lo(lo),
    .hi(hi),
    .n_cycles(n_cycles),
    .count(count),
    .dir(dir),
    .busy(busy),
    .done(done),
    .err(err),
    .cycles_left(cycles_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the expectation for the latest edge and compares every output
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== e.c || dir !== e.d || busy !== e.b || done !== e.dn ||
          err !== e.e || cycles_left !== e.cl) begin
        errors++;
        $display("FAIL %s: got count=%0d dir=%0b busy=%0b done=%0b err=%0b cl=%0d, want count=%0d dir=%0b busy=%0b done=%0b err=%0b cl=%0d",
                 e.tag, count, dir, busy, done, err, cycles_left,
                 e.c, e.d, e.b, e.dn, e.e, e.cl);
      end
    end
  end

  task automatic step(input logic st, input logic ab, input logic hd,
                      input logic [3:0] l, input logic [3:0] h, input logic [3:0] n,
                      input logic [3:0] ec, input logic ed, input logic eb,
                      input logic edn, input logic ee, input logic [3:0] ecl,
                      input string tag);
    exp_t e;
    start    = st;
    abort    = ab;
    hold     = hd;
    lo       = l;
    hi       = h;
    n_cycles = n;
    @(posedge clk);
    e.c = ec; e.d = ed; e.b = eb; e.dn = edn; e.e = ee; e.cl = ecl; e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    logic [3:0] t1c [13];
    logic [3:0] t5c [5];
    logic [4:0] t5d, t5b, t5dn, t5cl;
    t1c = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    t5c = '{4'd4, 4'd5, 4'd4, 4'd3, 4'd3};
    t5d  = 5'b00001;  // bit j-1 is step j
    t5b  = 5'b00111;
    t5dn = 5'b01000;
    t5cl = 5'b00111;

    rst = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    lo = 4'd0; hi = 4'd0; n_cycles = 4'd0;
    #1;

    // reset state
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "reset0");
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "reset1");
    rst = 1'b1;

    // lo=2 hi=5 n=2; start at k=4 (busy) and start+abort in DONE are ignored
    for (int k = 0; k <= 13; k++) begin
      logic st;
      st = (k == 0) || (k == 4) || (k == 13);
      step(st, (k == 13), 1'b0,
           (k == 0) ? 4'd2 : 4'd0, (k == 0) ? 4'd5 : 4'd9, (k == 0) ? 4'd2 : 4'd5,
           (k < 13) ? t1c[k] : 4'd2,
           (k < 3) || (k >= 6 && k < 9),
           (k < 12), (k == 12), 1'b0,
           (k < 6) ? 4'd2 : ((k < 12) ? 4'd1 : 4'd0),
           $sformatf("sweep2_5_k%0d", k));
    end

    // full range lo=0 hi=15 n=1
    for (int k = 0; k <= 31; k++) begin
      step((k == 0), 1'b0, 1'b0, 4'd0, 4'd15, 4'd1,
           (k <= 15) ? 4'(k) : ((k <= 30) ? 4'(30 - k) : 4'd0),
           (k < 15), (k < 30), (k == 30), 1'b0,
           (k < 30) ? 4'd1 : 4'd0,
           $sformatf("full_k%0d", k));
    end

    // rejected starts
    step(1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "err_lo_eq_hi");
    step(1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "err_clear0");
    step(1'b1, 1'b0, 1'b0, 4'd1, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "err_n_zero");
    step(1'b0, 1'b0, 1'b0, 4'd1, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "err_clear1");
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "err_lo_gt_hi");
    step(1'b0, 1'b0, 1'b0, 4'd9, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "err_clear2");

    // abort in DOWN at E0+11; start+abort in IDLE accepts the start; mid-sweep start ignored
    for (int k = 0; k <= 13; k++) begin
      step((k == 0) || (k == 5), (k == 0) || (k == 11), 1'b0,
           (k == 0) ? 4'd0 : 4'd2, (k == 0) ? 4'd8 : 4'd3, (k == 0) ? 4'd1 : 4'd4,
           (k <= 8) ? 4'(k) : ((k <= 10) ? 4'(16 - k) : 4'd0),
           (k < 8) || (k >= 11), (k <= 10), 1'b0, 1'b0,
           (k <= 10) ? 4'd1 : 4'd0,
           $sformatf("abort_k%0d", k));
    end

    // reset mid-sweep, then a fresh sweep
    for (int k = 0; k <= 3; k++) begin
      step((k == 0), 1'b0, 1'b0, 4'd1, 4'd6, 4'd1, 4'(1 + k), 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,
           $sformatf("prerst_k%0d", k));
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "midrst");
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "postrst_k0");
    for (int j = 1; j <= 5; j++) begin
      step(1'b0, 1'b0, 1'b0, 4'd3, 4'd5, 4'd1, t5c[j-1], t5d[j-1], t5b[j-1], t5dn[j-1],
           1'b0, t5cl[j-1] ? 4'd1 : 4'd0, $sformatf("postrst_k%0d", j));
    end

`ifdef SWEEP_HOLD_EN
    // hold for 3 cycles after E0+2 delays completion by 3
    for (int k = 0; k <= 10; k++) begin
      logic [3:0] c;
      if (k <= 2) c = 4'(2 + k);
      else if (k <= 5) c = 4'd4;
      else if (k == 6) c = 4'd5;
      else if (k == 7) c = 4'd4;
      else if (k == 8) c = 4'd3;
      else c = 4'd2;
      step((k == 0), 1'b0, (k >= 3 && k <= 5), 4'd2, 4'd5, 4'd1,
           c, (k < 6), (k < 9), (k == 9), 1'b0, (k < 9) ? 4'd1 : 4'd0,
           $sformatf("hold_k%0d", k));
    end
    // abort beats hold
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "holdab_k0");
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "holdab_k1");
    step(1'b0, 1'b1, 1'b1, 4'd2, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "holdab_k2");
    step(1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "holdab_k3");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want finish before it");
    $fatal(1, "timeout");
  end

endmodule
